// File: rtl/rob_alloc_ctrl.sv
// Dual-issue ROB tag allocator / in-order retire sequencer feeding the rename table push/pop/flush ports.
// Grants and pops are combinational from registered state; define ROB_PERF_CNT_EN to add the perf counters.
module rob_alloc_ctrl #(
    parameter int NUM_ENTRIES = 32,
    parameter int ADDR_W      = 5,
    parameter int REG_W       = 5,
    parameter int FLUSH_STALL = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              disp_req0,
    input  logic              disp_req1,
    input  logic              disp_wen0,
    input  logic              disp_wen1,
    input  logic              disp_spec0,
    input  logic              disp_spec1,
    input  logic [REG_W-1:0]  disp_dst0,
    input  logic [REG_W-1:0]  disp_dst1,
    output logic              disp_gnt0,
    output logic              disp_gnt1,
    output logic [ADDR_W-1:0] disp_rob0,
    output logic [ADDR_W-1:0] disp_rob1,
    input  logic              cmpl_vld0,
    input  logic              cmpl_vld1,
    input  logic [ADDR_W-1:0] cmpl_addr0,
    input  logic [ADDR_W-1:0] cmpl_addr1,
    output logic              push0,
    output logic              push1,
    output logic              spec0,
    output logic              spec1,
    output logic [REG_W-1:0]  push_reg_addr0,
    output logic [REG_W-1:0]  push_reg_addr1,
    output logic [ADDR_W-1:0] push_rob_addr0,
    output logic [ADDR_W-1:0] push_rob_addr1,
    output logic              pop0,
    output logic              pop1,
    output logic [REG_W-1:0]  pop_reg_addr0,
    output logic [REG_W-1:0]  pop_reg_addr1,
    output logic [ADDR_W-1:0] pop_rob_addr0,
    output logic [ADDR_W-1:0] pop_rob_addr1,
    output logic              rt_flush,
    output logic              full,
    output logic              empty
`ifdef ROB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_retired,
    output logic [31:0]       perf_full_stall
`endif
);

    localparam int HCW = $clog2(FLUSH_STALL + 1);
    localparam logic [ADDR_W:0] DEPTH    = (ADDR_W + 1)'(NUM_ENTRIES);
    localparam logic [ADDR_W:0] DEPTH_M2 = (ADDR_W + 1)'(NUM_ENTRIES - 2);

    typedef enum logic {RUN, HOLD} state_t;

    state_t               state_q, state_d;
    logic [HCW-1:0]       hold_q, hold_d;
    logic                 rt_flush_q, rt_flush_d;
    logic [ADDR_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [ADDR_W:0]      count_q, count_d;
    logic [NUM_ENTRIES-1:0] vld_q, vld_d, done_q, done_d, wen_q, wen_d;
    logic [REG_W-1:0]     dst_q [NUM_ENTRIES];
    logic [REG_W-1:0]     dst_d [NUM_ENTRIES];

    logic              active, not_full, two_free;
    logic              gnt0, gnt1, ret0, ret1;
    logic [1:0]        gnt_n, ret_n;
    logic [ADDR_W-1:0] head1, rob1;

    // Nothing is granted or retired while held, while flushing, or while in reset.
    assign active   = (state_q == RUN) & ~flush & ~reset;
    assign not_full = (count_q != DEPTH);
    assign two_free = (count_q <= DEPTH_M2);
    assign head1    = head_q + ADDR_W'(1);
    assign rob1     = tail_q + ADDR_W'(disp_req0);

    assign gnt0  = active & disp_req0 & not_full;
    assign gnt1  = active & disp_req1 & (disp_req0 ? (gnt0 & two_free) : not_full);
    assign ret0  = active & vld_q[head_q] & done_q[head_q];
    assign ret1  = ret0 & vld_q[head1] & done_q[head1];
    assign gnt_n = {1'b0, gnt0} + {1'b0, gnt1};
    assign ret_n = {1'b0, ret0} + {1'b0, ret1};

    assign disp_gnt0      = gnt0;
    assign disp_gnt1      = gnt1;
    assign disp_rob0      = tail_q;
    assign disp_rob1      = rob1;
    assign push0          = gnt0 & disp_wen0;
    assign push1          = gnt1 & disp_wen1;
    assign spec0          = disp_spec0;
    assign spec1          = disp_spec1;
    assign push_reg_addr0 = disp_dst0;
    assign push_reg_addr1 = disp_dst1;
    assign push_rob_addr0 = tail_q;
    assign push_rob_addr1 = rob1;
    assign pop0           = ret0 & wen_q[head_q];
    assign pop1           = ret1 & wen_q[head1];
    assign pop_reg_addr0  = ret0 ? dst_q[head_q] : '0;
    assign pop_reg_addr1  = ret1 ? dst_q[head1] : '0;
    assign pop_rob_addr0  = ret0 ? head_q : '0;
    assign pop_rob_addr1  = ret1 ? head1 : '0;
    assign rt_flush       = rt_flush_q;
    assign full           = (count_q == DEPTH);
    assign empty          = (count_q == '0);

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        rt_flush_d = 1'b0;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        vld_d      = vld_q;
        done_d     = done_q;
        wen_d      = wen_q;
        dst_d      = dst_q;
        if (flush) begin
            state_d    = HOLD;
            hold_d     = HCW'(FLUSH_STALL - 1);
            rt_flush_d = 1'b1;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            vld_d      = '0;
            done_d     = '0;
        end else begin
            if (state_q == HOLD) begin
                if (hold_q == '0) state_d = RUN;
                else              hold_d  = hold_q - HCW'(1);
            end
            if (ret0) begin
                vld_d[head_q]  = 1'b0;
                done_d[head_q] = 1'b0;
            end
            if (ret1) begin
                vld_d[head1]  = 1'b0;
                done_d[head1] = 1'b0;
            end
            if (gnt0) begin
                vld_d[tail_q]  = 1'b1;
                done_d[tail_q] = 1'b0;
                wen_d[tail_q]  = disp_wen0;
                dst_d[tail_q]  = disp_dst0;
            end
            if (gnt1) begin
                vld_d[rob1]  = 1'b1;
                done_d[rob1] = 1'b0;
                wen_d[rob1]  = disp_wen1;
                dst_d[rob1]  = disp_dst1;
            end
            // Checked after allocation so a tag granted and completed together ends up done.
            if (cmpl_vld0 && vld_d[cmpl_addr0]) done_d[cmpl_addr0] = 1'b1;
            if (cmpl_vld1 && vld_d[cmpl_addr1]) done_d[cmpl_addr1] = 1'b1;
            head_d  = head_q + ADDR_W'(ret_n);
            tail_d  = tail_q + ADDR_W'(gnt_n);
            count_d = count_q + (ADDR_W + 1)'(gnt_n) - (ADDR_W + 1)'(ret_n);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            hold_q     <= '0;
            rt_flush_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            vld_q      <= '0;
            done_q     <= '0;
            wen_q      <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) dst_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            rt_flush_q <= rt_flush_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            vld_q      <= vld_d;
            done_q     <= done_d;
            wen_q      <= wen_d;
            for (int i = 0; i < NUM_ENTRIES; i++) dst_q[i] <= dst_d[i];
        end
    end

`ifdef ROB_PERF_CNT_EN
    logic [31:0] perf_ret_q, perf_ret_d, perf_stall_q, perf_stall_d;
    logic [32:0] ret_sum;
    logic        full_stall;

    assign ret_sum    = {1'b0, perf_ret_q} + 33'(ret_n);
    assign full_stall = active & (disp_req0 | disp_req1) & ~not_full;

    // Both counters saturate and survive flush; only reset clears them.
    always_comb begin
        perf_ret_d   = ret_sum[32] ? '1 : ret_sum[31:0];
        perf_stall_d = perf_stall_q;
        if (full_stall && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_ret_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_ret_q   <= perf_ret_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_retired    = perf_ret_q;
    assign perf_full_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Randomised and directed bench for rob_alloc_ctrl, checked every cycle against a queue model of in-flight tags.
module tb_rob_alloc_ctrl;
    localparam int N  = 32;
    localparam int AW = 5;
    localparam int RW = 5;
    localparam int FS = 2;

    logic clk = 1'b0;
    logic reset = 1'b1, flush = 1'b0;
    logic req0 = 0, req1 = 0, wen0 = 0, wen1 = 0, sp0 = 0, sp1 = 0;
    logic [RW-1:0] dst0 = '0, dst1 = '0;
    logic cv0 = 0, cv1 = 0;
    logic [AW-1:0] ca0 = '0, ca1 = '0;

    logic gnt0, gnt1, push0, push1, spec0, spec1, pop0, pop1, rt_flush, full, empty;
    logic [AW-1:0] rob0, rob1, push_rob0, push_rob1, pop_rob0, pop_rob1;
    logic [RW-1:0] push_reg0, push_reg1, pop_reg0, pop_reg1;
`ifdef ROB_PERF_CNT_EN
    logic [31:0] perf_retired, perf_full_stall;
`endif

    always #5 clk = ~clk;

    rob_alloc_ctrl #(.NUM_ENTRIES(N), .ADDR_W(AW), .REG_W(RW), .FLUSH_STALL(FS)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .disp_req0(req0), .disp_req1(req1), .disp_wen0(wen0), .disp_wen1(wen1),
        .disp_spec0(sp0), .disp_spec1(sp1), .disp_dst0(dst0), .disp_dst1(dst1),
        .disp_gnt0(gnt0), .disp_gnt1(gnt1), .disp_rob0(rob0), .disp_rob1(rob1),
        .cmpl_vld0(cv0), .cmpl_vld1(cv1), .cmpl_addr0(ca0), .cmpl_addr1(ca1),
        .push0(push0), .push1(push1), .spec0(spec0), .spec1(spec1),
        .push_reg_addr0(push_reg0), .push_reg_addr1(push_reg1),
        .push_rob_addr0(push_rob0), .push_rob_addr1(push_rob1),
        .pop0(pop0), .pop1(pop1), .pop_reg_addr0(pop_reg0), .pop_reg_addr1(pop_reg1),
        .pop_rob_addr0(pop_rob0), .pop_rob_addr1(pop_rob1),
        .rt_flush(rt_flush), .full(full), .empty(empty)
`ifdef ROB_PERF_CNT_EN
        , .perf_retired(perf_retired), .perf_full_stall(perf_full_stall)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: ordered list of in-flight tags plus the hold window.
    typedef struct {
        int tag;
        bit wen;
        int dst;
        bit done;
    } ent_t;

    ent_t   mq[$];
    int     m_tail = 0;
    bit     m_hold = 0;
    int     m_hold_left = 0;
    bit     m_rtf = 0;
    bit     m_valid = 0;
    longint m_perf_ret = 0;
    longint m_perf_stall = 0;

    always @(negedge clk) begin : cmp_proc
        bit act, g0, g1, r0, r1;
        int cnt;
        ent_t e;
        act = !reset && !m_hold && !flush;
        cnt = mq.size();
        g0  = act && req0 && (cnt < N);
        g1  = act && req1 && (req0 ? (g0 && cnt <= N - 2) : (cnt < N));
        r0  = act && (cnt >= 1) && mq[0].done;
        r1  = r0 && (cnt >= 2) && mq[1].done;
        if (m_valid) begin
            check("gnt0", gnt0, g0);
            check("gnt1", gnt1, g1);
            check("push0", push0, g0 && wen0);
            check("push1", push1, g1 && wen1);
            if (g0) begin
                check("disp_rob0", rob0, m_tail);
                check("push_rob0", push_rob0, m_tail);
                check("push_reg0", push_reg0, dst0);
                check("spec0", spec0, sp0);
            end
            if (g1) begin
                check("disp_rob1", rob1, (m_tail + (req0 ? 1 : 0)) % N);
                check("push_rob1", push_rob1, (m_tail + (req0 ? 1 : 0)) % N);
                check("push_reg1", push_reg1, dst1);
                check("spec1", spec1, sp1);
            end
            check("pop0", pop0, r0 && mq[0].wen);
            check("pop1", pop1, r1 && mq[1].wen);
            if (r0 && mq[0].wen) begin
                check("pop_rob0", pop_rob0, mq[0].tag);
                check("pop_reg0", pop_reg0, mq[0].dst);
            end
            if (r1 && mq[1].wen) begin
                check("pop_rob1", pop_rob1, mq[1].tag);
                check("pop_reg1", pop_reg1, mq[1].dst);
            end
            check("full", full, cnt == N);
            check("empty", empty, cnt == 0);
            check("rt_flush", rt_flush, m_rtf);
`ifdef ROB_PERF_CNT_EN
            check("perf_retired", perf_retired, m_perf_ret);
            check("perf_full_stall", perf_full_stall, m_perf_stall);
`endif
        end
        if (reset) begin
            mq.delete();
            m_tail = 0; m_hold = 0; m_hold_left = 0; m_rtf = 0;
            m_perf_ret = 0; m_perf_stall = 0;
            m_valid = 1;
        end else if (m_valid) begin
            m_rtf = 0;
            if (r0) m_perf_ret++;
            if (r1) m_perf_ret++;
            if (act && (req0 || req1) && cnt == N) m_perf_stall++;
            if (flush) begin
                mq.delete();
                m_tail = 0; m_hold = 1; m_hold_left = FS; m_rtf = 1;
            end else begin
                if (m_hold) begin
                    m_hold_left--;
                    if (m_hold_left == 0) m_hold = 0;
                end
                if (r1) void'(mq.pop_front());
                if (r0) void'(mq.pop_front());
                if (g0) begin
                    e.tag = m_tail; e.wen = wen0; e.dst = int'(dst0); e.done = 0;
                    mq.push_back(e);
                    m_tail = (m_tail + 1) % N;
                end
                if (g1) begin
                    e.tag = m_tail; e.wen = wen1; e.dst = int'(dst1); e.done = 0;
                    mq.push_back(e);
                    m_tail = (m_tail + 1) % N;
                end
                foreach (mq[i]) begin
                    if (cv0 && mq[i].tag == int'(ca0)) mq[i].done = 1;
                    if (cv1 && mq[i].tag == int'(ca1)) mq[i].done = 1;
                end
            end
        end
    end

    task automatic idle();
        flush = 0; req0 = 0; req1 = 0; wen0 = 0; wen1 = 0; sp0 = 0; sp1 = 0;
        dst0 = '0; dst1 = '0; cv0 = 0; cv1 = 0; ca0 = '0; ca1 = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    initial begin
        idle();
        reset = 1;
        cyc(); cyc();
        reset = 0;
        neg();
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_rt_flush", rt_flush, 0);
        check("rst_pop0", pop0, 0);
        cyc();

        // Three dual dispatches: tags (0,1),(2,3),(4,5), only slot 0 writes.
        for (int k = 0; k < 3; k++) begin
            req0 = 1; req1 = 1; wen0 = 1; wen1 = 0;
            dst0 = RW'(k + 1); dst1 = RW'(k + 7);
            neg();
            check("lit_rob0", rob0, 2 * k);
            check("lit_rob1", rob1, 2 * k + 1);
            check("lit_gnt1", gnt1, 1);
            check("lit_push0", push0, 1);
            check("lit_push1", push1, 0);
            cyc();
        end

        // Fill to 32 without completions.
        wen1 = 1;
        for (int k = 0; k < 13; k++) cyc();
        neg();
        check("lit_full", full, 1);
        check("lit_full_gnt0", gnt0, 0);
        check("lit_full_gnt1", gnt1, 0);
        cyc();
        idle(); cv0 = 1; ca0 = '0;
        cyc();
        idle(); req0 = 1;
        neg();
        check("lit_pop0_full", pop0, 1);
        check("lit_pop_rob0_full", pop_rob0, 0);
        check("lit_pop1_full", pop1, 0);
        check("lit_no_regrant_same", gnt0, 0);
        cyc();
        neg();
        check("lit_regrant_gnt0", gnt0, 1);
        check("lit_regrant_rob0", rob0, 0);
        cyc();

        // Reset and flush together mid-stream.
        reset = 1; flush = 1;
        cyc();
        reset = 0; idle();
        neg();
        check("lit_rstflush_rtf", rt_flush, 0);
        check("lit_rstflush_empty", empty, 1);
        cyc();

        // Out-of-order completion; wen=0 entry retires without a pop.
        req0 = 1; req1 = 1; wen0 = 1; wen1 = 0; dst0 = 5'd3;
        cyc();
        idle(); cv1 = 1; ca1 = 5'd1;
        cyc();
        idle(); cv0 = 1; ca0 = 5'd0;
        neg();
        check("lit_ooo_pop0", pop0, 0);
        cyc();
        idle();
        neg();
        check("lit_pair_pop0", pop0, 1);
        check("lit_pair_reg0", pop_reg0, 3);
        check("lit_pair_pop1", pop1, 0);
        cyc();
        neg();
        check("lit_pair_empty", empty, 1);
        cyc();

        // Flush with count=10, then the hold window.
        for (int k = 0; k < 5; k++) begin
            req0 = 1; req1 = 1;
            cyc();
        end
        idle(); flush = 1; req0 = 1;
        neg();
        check("lit_flush_gnt0", gnt0, 0);
        cyc();
        flush = 0;
        neg();
        check("lit_hold1_rtf", rt_flush, 1);
        check("lit_hold1_empty", empty, 1);
        check("lit_hold1_gnt0", gnt0, 0);
        cyc();
        neg();
        check("lit_hold2_rtf", rt_flush, 0);
        check("lit_hold2_gnt0", gnt0, 0);
        cyc();
        neg();
        check("lit_run_gnt0", gnt0, 1);
        check("lit_run_rob0", rob0, 0);
        cyc();

        // Wrap: walk the head to 30, then retire 30,31 and 0.
        idle(); reset = 1;
        cyc();
        reset = 0;
        for (int k = 0; k < 16; k++) begin
            req0 = 1; req1 = 1; wen0 = 1; wen1 = 1;
            cv0 = 1; ca0 = AW'(2 * k); cv1 = 1; ca1 = AW'(2 * k + 1);
            cyc();
        end
        idle(); req0 = 1; wen0 = 1; dst0 = 5'd9; cv0 = 1; ca0 = '0;
        neg();
        check("lit_wrap_pop0", pop0, 1);
        check("lit_wrap_rob0", pop_rob0, 30);
        check("lit_wrap_pop1", pop1, 1);
        check("lit_wrap_rob1", pop_rob1, 31);
        check("lit_wrap_gnt_rob0", rob0, 0);
        cyc();
        idle();
        neg();
        check("lit_wrap2_pop0", pop0, 1);
        check("lit_wrap2_rob0", pop_rob0, 0);
        check("lit_wrap2_pop1", pop1, 0);
        cyc();
        neg();
        check("lit_wrap_empty", empty, 1);
        cyc();

        // Randomised traffic in phases of differing completion rate.
        for (int ph = 0; ph < 8; ph++) begin
            int cpct;
            cpct = (ph % 2 == 0) ? 10 : 70;
            for (int c = 0; c < 500; c++) begin
                idle();
                reset = ($urandom_range(0, 399) == 0);
                flush = ($urandom_range(0, 149) == 0);
                req0  = ($urandom_range(0, 99) < 70);
                req1  = ($urandom_range(0, 99) < 70);
                wen0  = 1'($urandom); wen1 = 1'($urandom);
                sp0   = 1'($urandom); sp1  = 1'($urandom);
                dst0  = RW'($urandom); dst1 = RW'($urandom);
                cv0   = ($urandom_range(0, 99) < cpct);
                cv1   = ($urandom_range(0, 99) < cpct);
                if (mq.size() > 0 && $urandom_range(0, 4) != 0)
                    ca0 = AW'(mq[$urandom_range(0, mq.size() - 1)].tag);
                else
                    ca0 = AW'($urandom);
                if (mq.size() > 0 && $urandom_range(0, 4) != 0)
                    ca1 = AW'(mq[$urandom_range(0, mq.size() - 1)].tag);
                else
                    ca1 = AW'($urandom);
                cyc();
            end
        end
        idle(); reset = 0;
        cyc(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
